// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM state encoding,
// owner identifiers and default widths.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_LAT = 1;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_LD   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to whichever
// requester did not own the previous transaction.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = OWN_CORE;
        case (req)
            2'b01:   gnt_id = OWN_CORE;
            2'b10:   gnt_id = OWN_LD;
            2'b11:   gnt_id = ~last;
            default: gnt_id = OWN_CORE;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes core and loader accesses onto one synchronous RAM with
// round-robin tie breaking and a one-cycle acknowledge per transaction.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [31:0]       core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    output logic              core_hold,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant,
    output arb_state_t        dbg_state
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    // Handshake: each requester holds its level request until it sees its
    // one-cycle ack, and drops it in the following cycle.

    arb_state_t        state_q, state_d;
    logic              owner_q;
    logic              op_we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] ld_rdata_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              core_req;
    logic              gnt_valid;
    logic              gnt_id;
    logic              take;
    logic              capture;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              addr_unused;

    assign core_req    = core_rd | core_wr;
    assign addr_unused = ^core_addr;

    mem_arb_rr u_rr (
        .req       ({ld_req, core_req}),
        .last      (owner_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Core write wins over a simultaneous core read.
    assign sel_we    = (gnt_id == OWN_LD) ? ld_we    : core_wr;
    assign sel_addr  = (gnt_id == OWN_LD) ? ld_addr  : core_addr[ADDR_W-1:0];
    assign sel_wdata = (gnt_id == OWN_LD) ? ld_wdata : core_wdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    take    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (op_we_q) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Owner resets to the loader so the core takes the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_LD;
            op_we_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rdata_q <= '0;
            ld_rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                owner_q <= gnt_id;
                op_we_q <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (capture) begin
                if (owner_q == OWN_LD) begin
                    ld_rdata_q <= mem_rdata;
                end else begin
                    core_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_we     = (state_q == ST_ISSUE) &  op_we_q;
    assign mem_re     = (state_q == ST_ISSUE) & ~op_we_q;
    assign core_ack   = (state_q == ST_DONE) & (owner_q == OWN_CORE);
    assign ld_ack     = (state_q == ST_DONE) & (owner_q == OWN_LD);
    assign core_hold  = core_req & ~core_ack;
    assign core_rdata = core_rdata_q;
    assign ld_rdata   = ld_rdata_q;
    assign grant      = owner_q;
    assign dbg_state  = state_q;

endmodule
